// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction memory address/data plus decode-side
// control (stall, redirects, halt) and the instruction register outputs.
interface fetch_if #(
    parameter int PC_WIDTH    = 10,
    parameter int INSTR_WIDTH = 32
);
    logic [PC_WIDTH-1:0]    ProgCounter;
    logic [INSTR_WIDTH-1:0] InstrIn;
    logic                   Stall;
    logic                   Branch;
    logic [15:0]            BranchOffset;
    logic                   Jump;
    logic [25:0]            JumpTarget;
    logic                   JumpReg;
    logic [31:0]            RegTarget;
    logic                   Halt;
    logic [INSTR_WIDTH-1:0] IR;
    logic                   IRValid;
    logic [PC_WIDTH-1:0]    IRPC;
    logic [PC_WIDTH-1:0]    IRPCPlus1;
    logic                   Halted;

    // Fetch unit side
    modport master (
        output ProgCounter, IR, IRValid, IRPC, IRPCPlus1, Halted,
        input  InstrIn, Stall, Branch, BranchOffset, Jump, JumpTarget,
               JumpReg, RegTarget, Halt
    );

    // Memory / decode side
    modport slave (
        input  ProgCounter, IR, IRValid, IRPC, IRPCPlus1, Halted,
        output InstrIn, Stall, Branch, BranchOffset, Jump, JumpTarget,
               JumpReg, RegTarget, Halt
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses instruction memory and
// latches the returned word into IR. Supports stall, branch/jump/jump-register
// redirects (one bubble) and a sticky halt that only reset clears.
module fetch_unit #(
    parameter int                  PC_WIDTH    = 10,
    parameter int                  INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic     clk,
    input  logic     reset,
    fetch_if.master  bus
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] ir_q, ir_d;
    logic                   irv_q, irv_d;
    logic [PC_WIDTH-1:0]    irpc_q, irpc_d;

    logic [PC_WIDTH-1:0]    pc_plus1;
    logic [PC_WIDTH-1:0]    irpc_plus1;
    logic [31:0]            off_ext;
    logic [PC_WIDTH-1:0]    redirect_target;
    logic                   redirect;
    logic                   unused_bits;

    assign pc_plus1   = pc_q + PC_WIDTH'(1);
    assign irpc_plus1 = irpc_q + PC_WIDTH'(1);
    assign off_ext    = {{16{bus.BranchOffset[15]}}, bus.BranchOffset};
    assign redirect   = bus.JumpReg | bus.Jump | bus.Branch;

    // Upper target/offset bits fall outside the PC and are intentionally dropped
    assign unused_bits = ^{bus.JumpTarget[25:PC_WIDTH], bus.RegTarget[31:PC_WIDTH],
                           off_ext[31:PC_WIDTH]};

    // Redirect target selection: JumpReg over Jump over Branch, all mod 2^PC_WIDTH
    always_comb begin
        redirect_target = irpc_plus1 + off_ext[PC_WIDTH-1:0];
        if (bus.JumpReg) begin
            redirect_target = bus.RegTarget[PC_WIDTH-1:0];
        end else if (bus.Jump) begin
            redirect_target = bus.JumpTarget[PC_WIDTH-1:0];
        end
    end

    // Next-state and register update decisions
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        irv_d   = irv_q;
        irpc_d  = irpc_q;
        unique case (state_q)
            BOOT: begin
                if (bus.Halt) begin
                    state_d = HALTED;
                    irv_d   = 1'b0;
                end else begin
                    ir_d    = bus.InstrIn;
                    irpc_d  = pc_q;
                    irv_d   = 1'b1;
                    pc_d    = pc_plus1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.Halt) begin
                    state_d = HALTED;
                    irv_d   = 1'b0;
                end else if (irv_q && redirect) begin
                    // Squash the wrong-path word; IRPC keeps the redirecting address
                    pc_d  = redirect_target;
                    irv_d = 1'b0;
                    ir_d  = '0;
                end else if (!bus.Stall) begin
                    ir_d   = bus.InstrIn;
                    irpc_d = pc_q;
                    irv_d  = 1'b1;
                    pc_d   = pc_plus1;
                end
            end
            HALTED: begin
                irv_d = 1'b0;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            irv_q   <= 1'b0;
            irpc_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            irv_q   <= irv_d;
            irpc_q  <= irpc_d;
        end
    end

    assign bus.ProgCounter = pc_q;
    assign bus.IR          = ir_q;
    assign bus.IRValid     = irv_q;
    assign bus.IRPC        = irpc_q;
    assign bus.IRPCPlus1   = irpc_plus1;
    assign bus.Halted      = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus updates a reference model and
// queues the expected post-edge state; a monitor compares after each edge.
module tb_fetch_unit;

    localparam int PCW = 10;
    localparam int IW  = 32;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fetch_if #(.PC_WIDTH(PCW), .INSTR_WIDTH(IW)) bus();

    fetch_unit #(.PC_WIDTH(PCW), .INSTR_WIDTH(IW), .RESET_PC(10'd0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] mem [0:1023];
    assign bus.InstrIn = mem[bus.ProgCounter];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] irv;
        logic [31:0] irpc;
        logic [31:0] irp1;
        logic [31:0] halted;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model state
    int          m_pc;
    int          m_irpc;
    logic [31:0] m_ir;
    bit          m_irv;
    bit          m_halt;
    bit          m_boot;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_pc   = 0;
        m_irpc = 0;
        m_ir   = '0;
        m_irv  = 1'b0;
        m_halt = 1'b0;
        m_boot = 1'b1;
    endfunction

    function automatic void model_fetch();
        m_ir   = mem[m_pc];
        m_irpc = m_pc;
        m_irv  = 1'b1;
        m_pc   = (m_pc + 1) % 1024;
    endfunction

    function automatic void model_edge();
        if (m_halt) return;
        if (m_boot) begin
            m_boot = 1'b0;
            if (bus.Halt) begin
                m_halt = 1'b1;
                m_irv  = 1'b0;
            end else begin
                model_fetch();
            end
            return;
        end
        if (bus.Halt) begin
            m_halt = 1'b1;
            m_irv  = 1'b0;
        end else if (m_irv && (bus.JumpReg || bus.Jump || bus.Branch)) begin
            if (bus.JumpReg)   m_pc = int'(bus.RegTarget % 32'd1024);
            else if (bus.Jump) m_pc = int'(bus.JumpTarget % 26'd1024);
            else               m_pc = (m_irpc + 1 + int'($signed(bus.BranchOffset))) & 1023;
            m_irv = 1'b0;
            m_ir  = '0;
        end else if (!bus.Stall) begin
            model_fetch();
        end
    endfunction

    // Apply the upcoming edge to the model, queue the expectation, advance
    task automatic step();
        exp_t e;
        if (reset) model_reset();
        else       model_edge();
        e.pc     = 32'(m_pc);
        e.ir     = m_ir;
        e.irv    = {31'd0, m_irv};
        e.irpc   = 32'(m_irpc);
        e.irp1   = 32'((m_irpc + 1) % 1024);
        e.halted = {31'd0, m_halt};
        sbq.push_back(e);
        @(negedge clk);
    endtask

    task automatic clear_ctl();
        bus.Stall        = 1'b0;
        bus.Branch       = 1'b0;
        bus.BranchOffset = '0;
        bus.Jump         = 1'b0;
        bus.JumpTarget   = '0;
        bus.JumpReg      = 1'b0;
        bus.RegTarget    = '0;
        bus.Halt         = 1'b0;
    endtask

    // Monitor: compare DUT state against the queued expectation after each edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("sb_pc",     32'(bus.ProgCounter), e.pc);
                chk("sb_ir",     bus.IR,               e.ir);
                chk("sb_irvalid", {31'd0, bus.IRValid}, e.irv);
                chk("sb_irpc",   32'(bus.IRPC),        e.irpc);
                chk("sb_irpcp1", 32'(bus.IRPCPlus1),   e.irp1);
                chk("sb_halted", {31'd0, bus.Halted},  e.halted);
            end
        end
    end

    // Watchdog bound on total run time
    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog expired");
    end

    // Stimulus: directed scenarios, then randomized traffic
    initial begin
        reset = 1'b1;
        clear_ctl();
        for (int k = 0; k < 1024; k++) mem[k] = $urandom();
        model_reset();
        @(negedge clk);
        chk("rst_pc",     32'(bus.ProgCounter), 32'd0);
        chk("rst_ir",     bus.IR,               32'd0);
        chk("rst_irvalid", {31'd0, bus.IRValid}, 32'd0);
        chk("rst_irpc",   32'(bus.IRPC),        32'd0);
        chk("rst_irpcp1", 32'(bus.IRPCPlus1),   32'd1);
        chk("rst_halted", {31'd0, bus.Halted},  32'd0);
        step();
        reset = 1'b0;

        // Boot then sequential fetch up to IRPC=2
        repeat (3) step();
        chk("seq_irpc", 32'(bus.IRPC), 32'd2);

        // Stall holds everything for 3 cycles
        bus.Stall = 1'b1;
        repeat (3) step();
        chk("stall_irpc", 32'(bus.IRPC),        32'd2);
        chk("stall_pc",   32'(bus.ProgCounter), 32'd3);
        bus.Stall = 1'b0;
        step();
        chk("post_stall_ir", bus.IR, mem[3]);
        repeat (2) step();
        chk("pre_branch_irpc", 32'(bus.IRPC), 32'd5);

        // Backward branch from IRPC=5 by -3 lands on 3, one bubble
        bus.Branch       = 1'b1;
        bus.BranchOffset = 16'hFFFD;
        step();
        clear_ctl();
        chk("branch_pc",  32'(bus.ProgCounter), 32'd3);
        chk("branch_squash", {31'd0, bus.IRValid}, 32'd0);
        step();
        chk("branch_ir",   bus.IR,        mem[3]);
        chk("branch_irpc", 32'(bus.IRPC), 32'd3);

        // Redirect overrides stall: 3+1-3 = 1
        bus.Branch       = 1'b1;
        bus.Stall        = 1'b1;
        bus.BranchOffset = 16'hFFFD;
        step();
        clear_ctl();
        chk("branch_stall_pc", 32'(bus.ProgCounter), 32'd1);
        step();

        // Jump beats branch, target truncated
        bus.Jump       = 1'b1;
        bus.Branch     = 1'b1;
        bus.JumpTarget = 26'h3FF0040;
        step();
        clear_ctl();
        chk("jump_pc", 32'(bus.ProgCounter), 32'h040);
        step();

        // JumpReg beats jump
        bus.JumpReg    = 1'b1;
        bus.Jump       = 1'b1;
        bus.RegTarget  = 32'h123;
        bus.JumpTarget = 26'h0000200;
        step();
        clear_ctl();
        chk("jr_pc", 32'(bus.ProgCounter), 32'h123);
        step();

        // Wrap at top of address space
        bus.JumpReg   = 1'b1;
        bus.RegTarget = 32'd1023;
        step();
        clear_ctl();
        step();
        chk("wrap_irpc",   32'(bus.IRPC),        32'd1023);
        chk("wrap_irpcp1", 32'(bus.IRPCPlus1),   32'd0);
        chk("wrap_pc",     32'(bus.ProgCounter), 32'd0);
        repeat (2) step();
        chk("wrap2_irpc", 32'(bus.IRPC), 32'd1);
        bus.Branch       = 1'b1;
        bus.BranchOffset = 16'hFFFB;
        step();
        clear_ctl();
        chk("neg_wrap_pc", 32'(bus.ProgCounter), 32'd1021);
        repeat (2) step();

        // Sticky halt with PC frozen at 1023
        bus.Halt = 1'b1;
        step();
        clear_ctl();
        chk("halt_flag",    {31'd0, bus.Halted},  32'd1);
        chk("halt_irvalid", {31'd0, bus.IRValid}, 32'd0);
        repeat (10) step();
        chk("halt_pc_frozen", 32'(bus.ProgCounter), 32'd1023);
        chk("halt_sticky",    {31'd0, bus.Halted},  32'd1);

        // Asynchronous reset mid-cycle, no clock edge needed
        #2;
        reset = 1'b1;
        #1;
        chk("areset_pc",     32'(bus.ProgCounter), 32'd0);
        chk("areset_halted", {31'd0, bus.Halted},  32'd0);
        chk("areset_irvalid", {31'd0, bus.IRValid}, 32'd0);
        chk("areset_irpcp1", 32'(bus.IRPCPlus1),   32'd1);
        step();
        reset = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            reset            = ($urandom_range(0, 249) == 0);
            bus.Halt         = ($urandom_range(0, 399) == 0);
            bus.Stall        = ($urandom_range(0, 3) == 0);
            bus.JumpReg      = ($urandom_range(0, 11) == 0);
            bus.Jump         = ($urandom_range(0, 11) == 0);
            bus.Branch       = ($urandom_range(0, 7) == 0);
            bus.BranchOffset = 16'($urandom());
            bus.JumpTarget   = 26'($urandom());
            bus.RegTarget    = $urandom();
            step();
        end
        reset = 1'b0;
        clear_ctl();
        step();

        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
